// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - video SRAM arbiter: A read priority, B read/write with starvation guard, write-to-read turnaround
module sram_port_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_A_RUN     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);
    localparam logic [7:0] RUN_MAX  = 8'(MAX_A_RUN);

    state_t            state, state_nxt;
    logic [3:0]        cyc, cyc_nxt;
    logic [7:0]        run, run_nxt;
    logic              cur_wr, wr_nxt;
    logic              cur_b, own_b_nxt;
    logic              pend_b, pend_b_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              a_ack_nxt, b_ack_nxt;
    logic              last_cyc, arb_point, grant_a, grant_b, grant_rd;

    assign last_cyc  = (cyc == LAST_CYC);
    assign arb_point = (state == IDLE) || ((state == ACCESS) && last_cyc);
    assign grant_b   = b_req && (!a_req || (run == RUN_MAX));
    assign grant_a   = a_req && !grant_b;
    assign grant_rd  = grant_a || !b_wren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cyc_nxt       = cyc;
        run_nxt       = run;
        wr_nxt        = cur_wr;
        own_b_nxt     = cur_b;
        pend_b_nxt    = pend_b;
        pend_addr_nxt = pend_addr;
        addr_nxt      = sram_addr;
        wdata_nxt     = sram_dout;
        a_ack_nxt     = 1'b0;
        b_ack_nxt     = 1'b0;

        case (state)
            ACCESS: begin
                if (!last_cyc) begin
                    cyc_nxt = cyc + 4'd1;
                end
            end
            TURN: begin
                // The grant was fixed when TURN was entered; just launch it.
                state_nxt = ACCESS;
                cyc_nxt   = 4'd0;
                wr_nxt    = 1'b0;
                own_b_nxt = pend_b;
                addr_nxt  = pend_addr;
                a_ack_nxt = !pend_b;
                b_ack_nxt = pend_b;
            end
            default: ;
        endcase

        if (arb_point) begin
            if (grant_a || grant_b) begin
                run_nxt = grant_b ? 8'd0 : ((run == RUN_MAX) ? run : run + 8'd1);
                if ((state == ACCESS) && cur_wr && grant_rd) begin
                    state_nxt     = TURN;
                    pend_b_nxt    = grant_b;
                    pend_addr_nxt = grant_b ? b_addr : a_addr;
                end else begin
                    state_nxt = ACCESS;
                    cyc_nxt   = 4'd0;
                    wr_nxt    = grant_b && b_wren;
                    own_b_nxt = grant_b;
                    addr_nxt  = grant_b ? b_addr : a_addr;
                    if (grant_b && b_wren) begin
                        wdata_nxt = b_wdata;
                    end
                    a_ack_nxt = grant_a;
                    b_ack_nxt = grant_b;
                end
            end else begin
                state_nxt = IDLE;
                run_nxt   = 8'd0;
            end
        end
    end

    // Pad controls are registered from the next-state view so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc          <= 4'd0;
            run          <= 8'd0;
            cur_wr       <= 1'b0;
            cur_b        <= 1'b0;
            pend_b       <= 1'b0;
            pend_addr    <= '0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            cyc          <= cyc_nxt;
            run          <= run_nxt;
            cur_wr       <= wr_nxt;
            cur_b        <= own_b_nxt;
            pend_b       <= pend_b_nxt;
            pend_addr    <= pend_addr_nxt;
            sram_addr    <= addr_nxt;
            sram_dout    <= wdata_nxt;
            sram_dout_en <= (state_nxt == ACCESS) && wr_nxt;
            sram_ce_n    <= (state_nxt != ACCESS);
            sram_oe_n    <= !((state_nxt == ACCESS) && !wr_nxt);
            sram_we_n    <= !((state_nxt == ACCESS) && wr_nxt && (cyc_nxt != LAST_CYC));
            a_ack        <= a_ack_nxt;
            b_ack        <= b_ack_nxt;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            if ((state == ACCESS) && last_cyc && !cur_wr) begin
                if (cur_b) begin
                    b_rdata  <= sram_din;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= sram_din;
                    a_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          a_req, a_ack, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic          b_req, b_wren, b_ack, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout, sram_din;
    logic          sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

    logic          a_req1, a_ack1, a_rvalid1;
    logic [AW-1:0] a_addr1;
    logic [DW-1:0] a_rdata1;
    logic          b_req1, b_wren1, b_ack1, b_rvalid1;
    logic [AW-1:0] b_addr1;
    logic [DW-1:0] b_wdata1, b_rdata1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1, sram_din1;
    logic          sram_dout_en1, sram_ce_n1, sram_oe_n1, sram_we_n1;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2), .MAX_A_RUN(8)) u0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4), .MAX_A_RUN(8)) u1 (
        .clk(clk), .rst(rst),
        .a_req(a_req1), .a_addr(a_addr1), .a_ack(a_ack1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req1), .b_wren(b_wren1), .b_addr(b_addr1), .b_wdata(b_wdata1),
        .b_ack(b_ack1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .sram_addr(sram_addr1), .sram_dout(sram_dout1), .sram_dout_en(sram_dout_en1), .sram_din(sram_din1),
        .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    logic log_en = 1'b0;
    logic pad_init = 1'b1;
    logic [DW-1:0] exp_a[$], exp_b[$], exp_a1[$];
    int grant_log[$];
    logic [DW-1:0] bref [16];
    logic [DW-1:0] pad [16];
    logic [3:0] acc1_cyc;
    logic prev_den;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Initial SRAM contents: known word at 0x00010, address-derived pattern elsewhere.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] ad);
        if (ad == 20'h00010) return 16'hBEEF;
        return ad[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Pad model for u0: B window 0x12340..0x1234F is writable, all else is ROM-like.
    always @(negedge clk) begin
        if (pad_init) begin
            for (int i = 0; i < 16; i++) pad[i] <= init_val(20'h12340 + 20'(i));
        end else if (!sram_ce_n && !sram_we_n && sram_dout_en && (sram_addr[19:4] == 16'h1234)) begin
            pad[sram_addr[3:0]] <= sram_dout;
        end
        if (!sram_ce_n && !sram_oe_n)
            sram_din <= (sram_addr[19:4] == 16'h1234) ? pad[sram_addr[3:0]] : init_val(sram_addr);
        else
            sram_din <= 16'h0BAD;
    end

    // Pad model for u1: data valid only in access cycle 3, so an early capture reads garbage.
    always @(posedge clk) begin
        if (rst) acc1_cyc <= 4'd0;
        else if (a_ack1) acc1_cyc <= 4'd1;
        else if (acc1_cyc != 4'd15) acc1_cyc <= acc1_cyc + 4'd1;
    end
    always @(negedge clk)
        sram_din1 <= (!sram_oe_n1 && !sram_ce_n1 && acc1_cyc == 4'd3) ? init_val(sram_addr1) : 16'h0BAD;

    // Monitor: pops scoreboard on every rvalid, watches pad protocol.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst) begin
            if (a_rvalid) begin
                if (exp_a.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 0);
                else begin e = exp_a.pop_front(); chk("a_rdata", 32'(a_rdata), 32'(e)); end
            end
            if (b_rvalid) begin
                if (exp_b.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 0);
                else begin e = exp_b.pop_front(); chk("b_rdata", 32'(b_rdata), 32'(e)); end
            end
            if (a_rvalid1) begin
                if (exp_a1.size() == 0) chk("a1_rvalid_unexpected", 32'(a_rvalid1), 0);
                else begin e = exp_a1.pop_front(); chk("a1_rdata", 32'(a_rdata1), 32'(e)); end
            end
            if (b_ack1 || b_rvalid1 || sram_dout_en1 || !sram_we_n1)
                chk("u1_b_side_idle", {28'd0, b_ack1, b_rvalid1, sram_dout_en1, !sram_we_n1}, 0);
            if (prev_den) chk("turnaround_oe_n", 32'(sram_oe_n), 1);
            if (sram_ce_n) chk("idle_pins", {29'd0, sram_oe_n, sram_we_n, sram_dout_en}, 32'b110);
            if (!sram_we_n) chk("write_window", 32'(sram_addr[19:4]), 32'h1234);
            if (log_en && a_ack) grant_log.push_back(cyc_cnt * 2);
            if (log_en && b_ack) grant_log.push_back(cyc_cnt * 2 + 1);
            prev_den <= sram_dout_en;
        end else begin
            prev_den <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port);
        int t = 0;
        do begin tick(); t++; end
        while (!(port == 0 ? a_ack : port == 1 ? b_ack : a_ack1) && t < 400);
        if (t >= 400) chk("ack_timeout", 32'(port), 32'hFFFF);
    endtask

    task automatic a_run(input int n, input int maxgap);
        logic [AW-1:0] ad;
        int gap;
        for (int k = 0; k < n; k++) begin
            ad = 20'($urandom_range(0, 255));
            exp_a.push_back(init_val(ad));
            a_addr = ad;
            a_req  = 1'b1;
            wait_ack(0);
            tick();
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (gap > 0 || k == n - 1) a_req = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic b_run(input int n, input int maxgap, input int wrmode);
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic wr;
        int gap;
        for (int k = 0; k < n; k++) begin
            ad = 20'h12340 | 20'($urandom_range(0, 15));
            wd = 16'($urandom);
            wr = (wrmode != 0) && ($urandom_range(0, 1) == 1);
            if (wr) bref[ad[3:0]] = wd;
            else exp_b.push_back(bref[ad[3:0]]);
            b_addr  = ad;
            b_wdata = wd;
            b_wren  = wr;
            b_req   = 1'b1;
            wait_ack(1);
            tick();
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (gap > 0 || k == n - 1) b_req = 1'b0;
            repeat (gap) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, t;
        logic [AW-1:0] ad;
        rst = 1'b1;
        a_req = 0; a_addr = 0; b_req = 0; b_wren = 0; b_addr = 0; b_wdata = 0;
        a_req1 = 0; a_addr1 = 0; b_req1 = 0; b_wren1 = 0; b_addr1 = 0; b_wdata1 = 0;
        for (int i = 0; i < 16; i++) bref[i] = init_val(20'h12340 + 20'(i));
        repeat (3) tick();
        pad_init = 1'b0;
        chk("rst_ctrl_pins", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'b1110);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dout", 32'(sram_dout), 0);
        chk("rst_handshakes", {28'd0, a_ack, b_ack, a_rvalid, b_rvalid}, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single A read of 0x00010.
        a_addr = 20'h00010; a_req = 1'b1; exp_a.push_back(16'hBEEF);
        tick();
        chk("a_ack_latency", 32'(a_ack), 1);
        chk("a_read_pins_c0", {30'd0, sram_ce_n, sram_oe_n}, 0);
        chk("a_read_addr", 32'(sram_addr), 32'h00010);
        tick();
        a_req = 1'b0;
        chk("a_ack_one_cycle", 32'(a_ack), 0);
        chk("a_read_pins_c1", {30'd0, sram_ce_n, sram_oe_n}, 0);
        tick();
        chk("a_rvalid_latency", 32'(a_rvalid), 1);
        chk("a_read_done_idle", {30'd0, sram_ce_n, sram_oe_n}, 32'b11);
        chk("b_side_quiet", {30'd0, b_ack, b_rvalid}, 0);
        repeat (2) tick();

        // B write 0x12345 then B read of the same word through TURN.
        b_addr = 20'h12345; b_wdata = 16'hA5A5; b_wren = 1'b1; b_req = 1'b1; bref[5] = 16'hA5A5;
        tick();
        chk("b_wr_ack", 32'(b_ack), 1);
        chk("b_wr_c0_pins", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'b0101);
        chk("b_wr_addr", 32'(sram_addr), 32'h12345);
        chk("b_wr_dout", 32'(sram_dout), 32'hA5A5);
        tick();
        b_wren = 1'b0; exp_b.push_back(bref[5]);
        chk("b_wr_c1_pins", {27'd0, b_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'b00111);
        tick();
        chk("turn_pins", {27'd0, b_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'b01110);
        chk("turn_addr_hold", 32'(sram_addr), 32'h12345);
        tick();
        chk("b_rd_ack_after_turn", 32'(b_ack), 1);
        chk("b_rd_pins", {30'd0, sram_ce_n, sram_oe_n}, 0);
        tick();
        b_req = 1'b0;
        tick();
        chk("b_rvalid_latency", 32'(b_rvalid), 1);
        repeat (2) tick();

        // Simultaneous requests from IDLE: A wins, B follows.
        ad = 20'($urandom_range(0, 255));
        a_addr = ad; a_req = 1'b1; exp_a.push_back(init_val(ad));
        b_addr = 20'h12341; b_wren = 1'b0; b_req = 1'b1; exp_b.push_back(bref[1]);
        tick();
        chk("tie_a_first", {30'd0, a_ack, b_ack}, 32'b10);
        tick();
        a_req = 1'b0;
        tick();
        chk("tie_b_next", {30'd0, a_ack, b_ack}, 32'b01);
        chk("rvalid_with_next_ack", 32'(a_rvalid), 1);
        tick();
        b_req = 1'b0;
        tick();
        chk("tie_b_rvalid", 32'(b_rvalid), 1);
        repeat (3) tick();

        // Saturated contention: 8 A grants then 1 B, no gaps.
        log_en = 1'b1;
        fork
            a_run(27, 0);
            b_run(3, 0, 0);
        join
        repeat (4) tick();
        log_en = 1'b0;
        chk("run_grant_count", grant_log.size(), 30);
        for (int i = 0; i < grant_log.size() && i < 30; i++) begin
            chk($sformatf("run_pattern_%0d", i), 32'(grant_log[i] % 2), (i % 9 == 8) ? 1 : 0);
            if (i > 0) chk($sformatf("run_spacing_%0d", i), 32'(grant_log[i] / 2 - grant_log[i-1] / 2), 2);
        end
        repeat (3) tick();

        // Reset during ACCESS cycle 0 of a write.
        b_addr = 20'h1234F; b_wdata = 16'h1357; b_wren = 1'b1; b_req = 1'b1;
        tick();
        chk("abort_wr_ack", 32'(b_ack), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_pins", {28'd0, sram_ce_n, sram_we_n, sram_dout_en, b_ack}, 32'b1100);
        b_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", {28'd0, a_ack, b_ack, a_rvalid, b_rvalid}, 0);
        end
        chk("post_rst_run", 32'(u0.run), 0);

        // Random mixed traffic with gaps, writes and turnarounds.
        fork
            a_run(40, 3);
            b_run(40, 3, 1);
        join
        repeat (6) tick();

        // ACCESS_CYCLES = 4 instance: single read, then ten back-to-back.
        ad = 20'h00055;
        a_addr1 = ad; a_req1 = 1'b1; exp_a1.push_back(init_val(ad));
        tick();
        chk("acc4_ack", 32'(a_ack1), 1);
        for (int c = 0; c < 4; c++) begin
            chk("acc4_ce_oe_low", {30'd0, sram_ce_n1, sram_oe_n1}, 0);
            chk("acc4_rvalid_early", 32'(a_rvalid1), 0);
            tick();
            if (c == 0) a_req1 = 1'b0;
        end
        chk("acc4_rvalid", 32'(a_rvalid1), 1);
        chk("acc4_ce_idle", 32'(sram_ce_n1), 1);
        repeat (2) tick();
        t0 = 0;
        for (int k = 0; k < 10; k++) begin
            ad = 20'($urandom_range(0, 255));
            a_addr1 = ad; a_req1 = 1'b1; exp_a1.push_back(init_val(ad));
            wait_ack(2);
            if (k == 0) t0 = cyc_cnt;
            tick();
            if (k == 9) a_req1 = 1'b0;
        end
        t = 0;
        while (!a_rvalid1 && t < 20) begin tick(); t++; end
        t1 = cyc_cnt;
        chk("acc4_b2b_40_cycles", 32'(t1 - t0), 40);
        repeat (3) tick();

        chk("exp_a_drained", exp_a.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);
        chk("exp_a1_drained", exp_a1.size(), 0);
        chk("u1_never_written", {b_rdata1, sram_dout1}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external video SRAM between two requesters.
  - Port A is the VGA scan-out reader: read-only, high priority.
  - Port B is the text/font renderer: read/write, low priority, with a starvation guard.
- Owns the SRAM control pins, sequences fixed-length accesses, and inserts bus turnaround cycles.
- Sits between the VGA timing block, the renderer and the SRAM pads.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
ACCESS_CYCLES, 2, clock cycles one SRAM access occupies (legal range 2..15)
MAX_A_RUN, 8, consecutive A grants after which a pending B request must win (legal range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
a_req  in  1  port A read request; held until a_ack
a_addr  in  ADDR_W  port A read address
a_ack  out  1  one-cycle pulse: A request accepted; a_addr has been latched
a_rvalid  out  1  one-cycle pulse: a_rdata is valid
a_rdata  out  DATA_W  port A read data; held until the next A read completes
b_req  in  1  port B request; held until b_ack
b_wren  in  1  1 = write, 0 = read
b_addr  in  ADDR_W  port B address
b_wdata  in  DATA_W  port B write data
b_ack  out  1  one-cycle pulse: B request accepted; address and data have been latched
b_rvalid  out  1  one-cycle pulse: b_rdata is valid (reads only)
b_rdata  out  DATA_W  port B read data; held until the next B read completes
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  write data to the pad tristate
sram_dout_en  out  1  drive enable for the data pads
sram_din  in  DATA_W  data from the pads
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state IDLE immediately, including mid-access, and sets:
  - sram_ce_n = sram_oe_n = sram_we_n = 1, sram_dout_en = 0;
  - sram_addr = 0, sram_dout = 0;
  - a_ack, b_ack, a_rvalid, b_rvalid = 0;
  - a_rdata, b_rdata = 0;
  - run counter = 0.
- All outputs are registered. No combinational path exists from any input to any output.
- States: IDLE, ACCESS, TURN.
- Arbitration point: the state register is in IDLE, or in the last ACCESS cycle.
  - If b_req && (!a_req || run == MAX_A_RUN), grant B.
  - Else if a_req, grant A.
  - Else go to IDLE.
  - B ties lose to A unless run has reached MAX_A_RUN.
- Run counter (8 bits):
  - increments on each A grant, saturating at MAX_A_RUN;
  - clears on a B grant or at an arbitration point with no request.
- Grant:
  - latches the address (and b_wdata / b_wren), then enters ACCESS with a cycle counter of 0;
  - the matching ack is high during ACCESS cycle 0 only;
  - the requester may change req, addr and data from the cycle after ack.
- ACCESS (ACCESS_CYCLES cycles):
  - sram_ce_n = 0 and sram_addr stays stable throughout.
  - Read: sram_oe_n = 0, sram_dout_en = 0. sram_din is captured on the last access cycle. The rdata register updates and rvalid pulses in the following cycle. Read latency from ack is ACCESS_CYCLES cycles.
  - Write: sram_oe_n = 1, sram_dout_en = 1, sram_dout stable. sram_we_n = 0 for cycles 0..ACCESS_CYCLES-2 and 1 on the last cycle, giving one cycle of data/address hold. No rvalid is generated.
- Back-to-back:
  - The arbitration point in the last ACCESS cycle may start the next access the next cycle, with no IDLE gap.
  - Sustained throughput is 1 access per ACCESS_CYCLES.
- Turnaround:
  - If a write is followed by a granted read, one TURN cycle is inserted: ce_n = 1, dout_en = 0, we_n = 1, oe_n = 1.
  - The read's ack moves into the first cycle after TURN.
  - Write→write, read→read and read→write have no gap.
  - The TURN decision is taken at the arbitration point; the grant is not re-evaluated in TURN.
- IDLE: ce_n = oe_n = we_n = 1, dout_en = 0.
- sram_addr holds its last value in IDLE and TURN.
- rvalid of a read and ack of the next access may be high in the same cycle. They belong to different transactions and the bench must accept this.

Test Plan:
- Reset, then a_req with a_addr = 0x00010 and sram_din = 0xBEEF. Expect a_ack 1 cycle after req, oe_n low for 2 cycles, a_rvalid with a_rdata = 0xBEEF 2 cycles after ack. b_* stays idle.
- B write addr 0x12345, data 0xA5A5. Expect b_ack, dout_en = 1 and we_n = 0 in cycle 0 only, we_n = 1 in cycle 1, and no b_rvalid. A following B read of 0x12345 takes the TURN cycle: ce_n = 1 for exactly 1 cycle before its ack.
- a_req and b_req held high continuously with MAX_A_RUN = 8. Expect the grant pattern 8×A, 1×B, repeating, with no idle cycles between accesses.
- a_req and b_req asserted in the same cycle from IDLE with run = 0. Expect A granted first, then B granted at the next arbitration point if a_req drops.
- Assert rst during ACCESS cycle 0 of a write. Expect we_n = 1, ce_n = 1 and dout_en = 0 the same cycle. No ack or rvalid until a new request arrives, and the run counter reads 0.
- ACCESS_CYCLES = 4: A read. Expect ce_n low for 4 cycles, capture on cycle 3, a_rvalid 4 cycles after a_ack. Ten back-to-back A reads take 40 cycles.
